// File: rtl/cdb_arbiter_pkg.sv
// Shared pipeline types for CDB result broadcast.
// Also used by the ROB and the reservation-station wakeup ports.
package cdb_arbiter_pkg;

  localparam int unsigned VALUE_W   = 64;
  localparam int unsigned PRF_IDX_W = 7;
  localparam int unsigned ROB_IDX_W = 6;

  typedef struct packed {
    logic [VALUE_W-1:0]   value;
    logic [PRF_IDX_W-1:0] tag;
    logic [ROB_IDX_W-1:0] rob_idx;
  } cdb_pkt_t;

  // Round-robin successor; n need not be a power of two.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU completion / CDB broadcast bundle.
//   slave  : arbiter side (takes FU results, drives ready and CDB)
//   master : FU / consumer side
interface cdb_arbiter_if #(
  parameter int unsigned N_FU = 4
);
  import cdb_arbiter_pkg::*;

  logic [N_FU-1:0]                fu_done_i;
  logic [N_FU-1:0][VALUE_W-1:0]   fu_result_i;
  logic [N_FU-1:0][PRF_IDX_W-1:0] fu_dest_tag_i;
  logic [N_FU-1:0][ROB_IDX_W-1:0] fu_rob_idx_i;
  logic [N_FU-1:0]                fu_ready_o;
  logic                           cdb_valid_o;
  logic [VALUE_W-1:0]             cdb_value_o;
  logic [PRF_IDX_W-1:0]           cdb_tag_o;
  logic [ROB_IDX_W-1:0]           cdb_rob_idx_o;

  modport slave (
    input  fu_done_i, fu_result_i, fu_dest_tag_i, fu_rob_idx_i,
    output fu_ready_o, cdb_valid_o, cdb_value_o, cdb_tag_o, cdb_rob_idx_o
  );

  modport master (
    output fu_done_i, fu_result_i, fu_dest_tag_i, fu_rob_idx_i,
    input  fu_ready_o, cdb_valid_o, cdb_value_o, cdb_tag_o, cdb_rob_idx_o
  );

endinterface

// File: rtl/cdb_arbiter_fifo.sv
// Per-FU completion FIFO (cdb_fifo role).
// Ports: clk, rst_n (async active-low), flush (sync clear), push/push_pkt,
//        pop, head_pkt, count, full, empty, overflow (push dropped on full).
// Push and pop on a full FIFO in the same cycle is legal.
module cdb_arbiter_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter  int unsigned Depth = 2,
  localparam int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            push,
  input  cdb_pkt_t        push_pkt,
  input  logic            pop,
  output cdb_pkt_t        head_pkt,
  output logic [CntW-1:0] count,
  output logic            full,
  output logic            empty,
  output logic            overflow
);

  localparam int unsigned PtrW = $clog2(Depth);

  cdb_pkt_t        mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            push_ok, do_push, do_pop;

  assign full     = (count_q == CntW'(Depth));
  assign empty    = (count_q == '0);
  assign push_ok  = push & ~flush;
  assign do_pop   = pop & ~empty & ~flush;
  // A full FIFO can still take a push if its head leaves this cycle.
  assign do_push  = push_ok & (~full | do_pop);
  assign overflow = push_ok & full & ~do_pop;
  assign head_pkt = mem_q[rd_ptr_q];
  assign count    = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_pkt;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Serialises FU completions onto the common data bus.
// Ports: clk, rst_n (async active-low), flush_i (squash all queued results),
//        bus (cdb_arbiter_if.slave: FU results in, fu_ready/CDB out),
//        overflow_o (sticky: a push hit a full FIFO that was not popped).
// One completion FIFO per FU; round-robin grant of one head per cycle.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned N_FU       = 4,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  cdb_arbiter_if.slave  bus,
  output logic          overflow_o
);

  localparam int unsigned IdxW = $clog2(N_FU);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  cdb_pkt_t        head_pkt [N_FU];
  logic [CntW-1:0] count    [N_FU];
  logic [N_FU-1:0] full, empty, ovf, pop, fu_ready;

  logic            grant_valid;
  logic [IdxW-1:0] grant_idx, cand_idx, rr_ptr_d, rr_ptr_q;
  logic            cdb_valid_q, overflow_q;
  cdb_pkt_t        cdb_pkt_q;

  for (genvar k = 0; k < N_FU; k++) begin : g_fifo
    cdb_pkt_t push_pkt;
    assign push_pkt = '{value:   bus.fu_result_i[k],
                        tag:     bus.fu_dest_tag_i[k],
                        rob_idx: bus.fu_rob_idx_i[k]};

    cdb_arbiter_fifo #(
      .Depth (FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush_i),
      .push     (bus.fu_done_i[k]),
      .push_pkt (push_pkt),
      .pop      (pop[k]),
      .head_pkt (head_pkt[k]),
      .count    (count[k]),
      .full     (full[k]),
      .empty    (empty[k]),
      .overflow (ovf[k])
    );
  end

  // Rotating priority scan from rr_ptr; first non-empty FIFO wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int unsigned i = 0; i < N_FU; i++) begin
      cand_idx = IdxW'((32'(rr_ptr_q) + i) % N_FU);
      if (!grant_valid && !empty[cand_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx;
      end
    end
    if (flush_i) grant_valid = 1'b0;
    rr_ptr_d = IdxW'(rr_next(32'(grant_idx), N_FU));
  end

  // Ready keeps one slot free for a result already in flight:
  // ready <=> count <= FIFO_DEPTH-2.
  always_comb begin
    pop      = '0;
    fu_ready = '0;
    for (int unsigned k = 0; k < N_FU; k++) begin
      pop[k]      = grant_valid && (grant_idx == IdxW'(k));
      fu_ready[k] = !full[k] && (count[k] != CntW'(FIFO_DEPTH - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_pkt_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      cdb_valid_q <= grant_valid;
      if (grant_valid) begin
        cdb_pkt_q <= head_pkt[grant_idx];
        rr_ptr_q  <= rr_ptr_d;
      end
      overflow_q <= overflow_q | (|ovf);
    end
  end

  assign bus.fu_ready_o    = fu_ready;
  assign bus.cdb_valid_o   = cdb_valid_q;
  assign bus.cdb_value_o   = cdb_pkt_q.value;
  assign bus.cdb_tag_o     = cdb_pkt_q.tag;
  assign bus.cdb_rob_idx_o = cdb_pkt_q.rob_idx;
  assign overflow_o        = overflow_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (N_FU=4, FIFO_DEPTH=2).
module tb_cdb_arbiter;

  logic clk;
  logic rst_n;
  logic flush;
  logic overflow;

  int n_tests = 0;
  int n_fail  = 0;

  cdb_arbiter_if #(.N_FU(4)) bus ();

  cdb_arbiter #(
    .N_FU       (4),
    .FIFO_DEPTH (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush),
    .bus        (bus),
    .overflow_o (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0] done;
    int         id;
    logic       exp_v;
    logic       chk_data;
    int         exp_fu;
    int         exp_id;
    logic [3:0] exp_ready;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs [20];

  function automatic logic [63:0] pv(input int id, input int k);
    return 64'h0000_0000_0000_A000 + 64'(id * 16 + k);
  endfunction

  function automatic logic [6:0] pt(input int id, input int k);
    return 7'((id * 4 + k) % 128);
  endfunction

  function automatic logic [5:0] pr(input int id, input int k);
    return 6'((id + k * 5) % 64);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] done, input int id);
    for (int k = 0; k < 4; k++) begin
      bus.fu_result_i[k]   = pv(id, k);
      bus.fu_dest_tag_i[k] = pt(id, k);
      bus.fu_rob_idx_i[k]  = pr(id, k);
    end
    bus.fu_done_i = done;
  endtask

  task automatic check_out(input string nm, input logic ev, input logic cd, input int efu,
                           input int eid, input logic [3:0] er, input logic eo);
    chk({nm, ".valid"}, 64'(bus.cdb_valid_o), 64'(ev));
    chk({nm, ".ready"}, 64'(bus.fu_ready_o), 64'(er));
    chk({nm, ".ovf"}, 64'(overflow), 64'(eo));
    if (cd) begin
      chk({nm, ".value"}, bus.cdb_value_o, pv(eid, efu));
      chk({nm, ".tag"}, 64'(bus.cdb_tag_o), 64'(pt(eid, efu)));
      chk({nm, ".rob"}, 64'(bus.cdb_rob_idx_o), 64'(pr(eid, efu)));
    end
  endtask

  initial begin
    // done, id, v, chk_data, fu, id, ready, ovf
    vecs[0]  = '{4'b1111, 1, 1'b0, 1'b0, 0, 0, 4'b0000, 1'b0};
    vecs[1]  = '{4'b0000, 0, 1'b1, 1'b1, 0, 1, 4'b0001, 1'b0};
    vecs[2]  = '{4'b0000, 0, 1'b1, 1'b1, 1, 1, 4'b0011, 1'b0};
    vecs[3]  = '{4'b0000, 0, 1'b1, 1'b1, 2, 1, 4'b0111, 1'b0};
    vecs[4]  = '{4'b0000, 0, 1'b1, 1'b1, 3, 1, 4'b1111, 1'b0};
    vecs[5]  = '{4'b0000, 0, 1'b0, 1'b1, 3, 1, 4'b1111, 1'b0};
    vecs[6]  = '{4'b1010, 2, 1'b0, 1'b1, 3, 1, 4'b0101, 1'b0};
    vecs[7]  = '{4'b0000, 0, 1'b1, 1'b1, 1, 2, 4'b0111, 1'b0};
    vecs[8]  = '{4'b0000, 0, 1'b1, 1'b1, 3, 2, 4'b1111, 1'b0};
    vecs[9]  = '{4'b0000, 0, 1'b0, 1'b1, 3, 2, 4'b1111, 1'b0};
    vecs[10] = '{4'b0001, 3, 1'b0, 1'b1, 3, 2, 4'b1110, 1'b0};
    vecs[11] = '{4'b0000, 0, 1'b1, 1'b1, 0, 3, 4'b1111, 1'b0};
    vecs[12] = '{4'b1001, 4, 1'b0, 1'b1, 0, 3, 4'b0110, 1'b0};
    vecs[13] = '{4'b0000, 0, 1'b1, 1'b1, 3, 4, 4'b1110, 1'b0};
    vecs[14] = '{4'b0000, 0, 1'b1, 1'b1, 0, 4, 4'b1111, 1'b0};
    vecs[15] = '{4'b0000, 0, 1'b0, 1'b1, 0, 4, 4'b1111, 1'b0};
    vecs[16] = '{4'b0100, 5, 1'b0, 1'b1, 0, 4, 4'b1011, 1'b0};
    vecs[17] = '{4'b0100, 6, 1'b1, 1'b1, 2, 5, 4'b1011, 1'b0};
    vecs[18] = '{4'b0000, 0, 1'b1, 1'b1, 2, 6, 4'b1111, 1'b0};
    vecs[19] = '{4'b0000, 0, 1'b0, 1'b1, 2, 6, 4'b1111, 1'b0};

    rst_n = 1'b0;
    flush = 1'b0;
    drive(4'b0000, 0);

    // Reset held 3 cycles with fu_done toggling: nothing may enqueue.
    for (int i = 0; i < 3; i++) begin
      drive(((i % 2) == 0) ? 4'b1111 : 4'b0101, 20 + i);
      tick();
      check_out($sformatf("rst%0d", i), 1'b0, 1'b0, 0, 0, 4'b1111, 1'b0);
      chk($sformatf("rst%0d.value", i), bus.cdb_value_o, 64'h0);
    end
    rst_n = 1'b1;
    drive(4'b0000, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("post_rst%0d", i), 1'b0, 1'b0, 0, 0, 4'b1111, 1'b0);
    end

    // Round-robin, hold, wrap-around and push-while-popping vectors.
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].done, vecs[i].id);
      tick();
      check_out($sformatf("row%0d", i), vecs[i].exp_v, vecs[i].chk_data, vecs[i].exp_fu,
                vecs[i].exp_id, vecs[i].exp_ready, vecs[i].exp_ovf);
    end

    // Single result from FU2: visible two cycles later, for one cycle.
    drive(4'b0000, 0);
    bus.fu_result_i[2]   = 64'h1234;
    bus.fu_dest_tag_i[2] = 7'd7;
    bus.fu_rob_idx_i[2]  = 6'd3;
    bus.fu_done_i        = 4'b0100;
    tick();
    drive(4'b0000, 0);
    chk("single.t1.valid", 64'(bus.cdb_valid_o), 64'h0);
    tick();
    chk("single.t2.valid", 64'(bus.cdb_valid_o), 64'h1);
    chk("single.t2.value", bus.cdb_value_o, 64'h1234);
    chk("single.t2.tag", 64'(bus.cdb_tag_o), 64'd7);
    chk("single.t2.rob", 64'(bus.cdb_rob_idx_o), 64'd3);
    tick();
    chk("single.t3.valid", 64'(bus.cdb_valid_o), 64'h0);

    // Flush with FU0..FU2 queued and FU1 done in the flush cycle; rr_ptr is 3.
    drive(4'b0111, 7);
    tick();
    check_out("fl.fill", 1'b0, 1'b0, 0, 0, 4'b1000, 1'b0);
    flush = 1'b1;
    drive(4'b0010, 8);
    tick();
    flush = 1'b0;
    drive(4'b0000, 0);
    check_out("fl.flush", 1'b0, 1'b0, 0, 0, 4'b1111, 1'b0);
    tick();
    check_out("fl.idle0", 1'b0, 1'b0, 0, 0, 4'b1111, 1'b0);
    tick();
    check_out("fl.idle1", 1'b0, 1'b0, 0, 0, 4'b1111, 1'b0);
    // rr_ptr kept at 3: FU3 must win over FU0.
    drive(4'b1001, 9);
    tick();
    drive(4'b0000, 0);
    check_out("fl.push", 1'b0, 1'b0, 0, 0, 4'b0110, 1'b0);
    tick();
    check_out("fl.g0", 1'b1, 1'b1, 3, 9, 4'b1110, 1'b0);
    tick();
    check_out("fl.g1", 1'b1, 1'b1, 0, 9, 4'b1111, 1'b0);
    tick();
    check_out("fl.end", 1'b0, 1'b0, 0, 0, 4'b1111, 1'b0);

    // Full FIFO0 granted in the same cycle as a push; rr_ptr is 1.
    drive(4'b0011, 10);
    tick();
    check_out("pp.c1", 1'b0, 1'b0, 0, 0, 4'b1100, 1'b0);
    drive(4'b0001, 11);
    tick();
    check_out("pp.c2", 1'b1, 1'b1, 1, 10, 4'b1110, 1'b0);
    drive(4'b0001, 12);
    tick();
    drive(4'b0000, 0);
    check_out("pp.c3", 1'b1, 1'b1, 0, 10, 4'b1110, 1'b0);
    tick();
    check_out("pp.c4", 1'b1, 1'b1, 0, 11, 4'b1110, 1'b0);
    tick();
    check_out("pp.c5", 1'b1, 1'b1, 0, 12, 4'b1111, 1'b0);
    tick();
    check_out("pp.c6", 1'b0, 1'b0, 0, 0, 4'b1111, 1'b0);

    // Back-pressure on FU0 behind FU1..FU3, then a push into the full FIFO.
    drive(4'b1110, 13);
    tick();
    check_out("bp.e1", 1'b0, 1'b0, 0, 0, 4'b0001, 1'b0);
    drive(4'b0001, 14);
    tick();
    check_out("bp.e2", 1'b1, 1'b1, 1, 13, 4'b0010, 1'b0);
    drive(4'b0001, 15);
    tick();
    check_out("bp.e3", 1'b1, 1'b1, 2, 13, 4'b0110, 1'b0);
    drive(4'b0001, 16);
    tick();
    drive(4'b0000, 0);
    check_out("bp.e4", 1'b1, 1'b1, 3, 13, 4'b1110, 1'b1);
    tick();
    check_out("bp.e5", 1'b1, 1'b1, 0, 14, 4'b1110, 1'b1);
    tick();
    check_out("bp.e6", 1'b1, 1'b1, 0, 15, 4'b1111, 1'b1);
    tick();
    check_out("bp.e7", 1'b0, 1'b0, 0, 0, 4'b1111, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_out("bp.flush", 1'b0, 1'b0, 0, 0, 4'b1111, 1'b1);

    // Asynchronous reset mid-cycle clears the sticky flag and data at once.
    #1;
    rst_n = 1'b0;
    #1;
    check_out("arst", 1'b0, 1'b0, 0, 0, 4'b1111, 1'b0);
    chk("arst.value", bus.cdb_value_o, 64'h0);
    tick();
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Collects completed results from the integer ALUs and other fixed-latency functional units and serialises them onto the single common data bus (CDB). The CDB feeds the ROB, physical register file, and reservation-station wakeup. Each FU gets a small completion FIFO. A round-robin arbiter grants one FIFO head per cycle. A per-FU ready signal tells issue logic when that FU may start a new operation.

## Interface
Parameters:
- N_FU, 4, number of FU completion ports (≥2)
- FIFO_DEPTH, 2, entries per completion FIFO (≥2, power of two)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush_i  in  1  mispredict squash; synchronously empties all FIFOs
- fu_done_i  in  N_FU  FU result valid, one cycle per result
- fu_result_i  in  N_FU×64  result value
- fu_dest_tag_i  in  N_FU×`PRF_IDX_W  destination physical register
- fu_rob_idx_i  in  N_FU×`ROB_IDX_W  ROB entry of the producing instruction
- fu_ready_o  out  N_FU  issue to FU k permitted this cycle
- cdb_valid_o  out  1  CDB broadcast valid (registered)
- cdb_value_o  out  64  broadcast value (registered)
- cdb_tag_o  out  `PRF_IDX_W  broadcast destination tag (registered)
- cdb_rob_idx_o  out  `ROB_IDX_W  broadcast ROB index (registered)
- overflow_o  out  1  sticky protocol-error flag: push into a full FIFO

## Operation
- **Enqueue.** At an edge where fu_done_i[k]=1 and flush_i=0, the packet {value, tag, rob_idx} is written at FIFO k's tail.
- **Grant.** Each cycle, the arbiter scans the non-empty FIFOs, starting at rr_ptr and wrapping modulo N_FU. The first one found is granted.
  - The granted head is popped and loaded into the CDB output registers with cdb_valid_o=1.
  - If no FIFO is non-empty, cdb_valid_o=0 and the data outputs hold their previous values.
- **Round-robin pointer.** After a grant to k, rr_ptr = (k+1) mod N_FU. With no grant, rr_ptr is unchanged.
- **Ready.** fu_ready_o[k] = (count[k] ≤ FIFO_DEPTH−2), computed combinationally from the registered count. This reserves one slot for a result already in flight from a 1-cycle FU.
- **Push and pop on the same FIFO in one cycle.** Both occur; count is unchanged.
  - A FIFO that is full at the start of the cycle may accept a push in the same cycle it is granted. This is not an overflow.
- **Overflow.** A push into a full FIFO that is not popped in the same cycle sets overflow_o. The packet is dropped and the FIFO contents are unchanged.
- **Flush.** At an edge with flush_i=1:
  - all counts and pointers clear to 0;
  - cdb_valid_o ← 0;
  - fu_done_i in the same cycle is ignored;
  - rr_ptr is kept;
  - overflow_o is kept.
- **CDB back-pressure.** There is none; the CDB always accepts a broadcast.

## Timing
- **Reset** (rst_n low, asynchronous): all FIFO counts and pointers = 0, rr_ptr = 0, cdb_valid_o = 0, cdb_value_o = 0, cdb_tag_o = 0, cdb_rob_idx_o = 0, overflow_o = 0.
  - fu_ready_o is therefore all ones during and after reset.
  - Deassertion takes effect at the first rising edge after rst_n goes high.
- **Latency.** fu_done_i high in cycle t, uncontended → cdb_valid_o high in cycle t+2. Enqueue occurs at the edge ending cycle t; the grant is registered at the edge ending cycle t+1. There is no bypass.
- **Contention.** A result waits at most N_FU−1 extra grant cycles per packet ahead of it in the round-robin order.
- **Throughput.** One broadcast per cycle, sustained while any FIFO is non-empty.
- **Ready to push spacing.** If fu_ready_o[k] is sampled high in cycle t and FU k issues, its result arrives at fu_done_i in cycle t+1 at the latest. A slot is guaranteed for it.

## Structure
- **Shared package.** `cdb_pkt_t` (packed struct: value[63:0], tag[`PRF_IDX_W-1:0], rob_idx[`ROB_IDX_W-1:0]) belongs in the shared pipeline package, reused by the ROB and RS wakeup ports.
- **Sub-module `cdb_fifo`.** One per FU. Parameterised by depth. It contains:
  - ports: push, push_pkt, pop, flush, head_pkt, count, full, empty;
  - behaviour: simultaneous push and pop on full is legal, and an overflow pulse is output.
- **Top level.** Contains the rr_ptr register, the rotating priority scan (generate loop), the CDB output registers, the sticky overflow flag, and the ready decode.

## Test plan
- **Reset.** Hold rst_n=0 for 3 cycles, with fu_done_i toggling. Expect: cdb_valid_o=0, fu_ready_o=4'b1111, overflow_o=0. After release, no spurious broadcast.
- **Single result.** FU2 done in cycle 5 with value 64'h1234, tag 7, rob 3. Expect: cdb_valid_o=1 in cycle 7 only, carrying {64'h1234, 7, 3}.
- **Round-robin.** All 4 FUs done in the same cycle, rr_ptr=0. Expect: broadcasts in order FU0, FU1, FU2, FU3 on 4 consecutive cycles. Then send a single new batch from FU1 and FU3. Expect: FU1 first, then FU3.
- **Backpressure.** Stall the grant of FU0 by keeping FU1–FU3 busy, and push two FU0 results. Expect: fu_ready_o[0]=0 once count=1. A third push while full and not popped sets overflow_o, which stays 1.
- **Flush.** Flush with 3 queued results and a simultaneous FU1 done. Expect:
  - next cycle cdb_valid_o=0, all fu_ready_o=1, no later broadcast of any flushed packet;
  - rr_ptr is preserved, checked by the next grant order.
- **Full-FIFO push+pop.** FIFO at depth 2 is granted in the same cycle as a push. Expect: count stays 2, overflow_o=0, FIFO order preserved.
